// File: rtl/modbus_req_decoder.sv
// Modbus RTU function 03h request decoder: captures header bytes from aRx,
// validates them, and reports an error class. Broadcast: `MODBUS_BROADCAST_EN.
module modbus_req_decoder #(
    parameter logic [7:0]  FUNC_CODE = 8'h03,
    parameter int unsigned MAX_QNTY  = 125,
    parameter int unsigned MIN_BYTES = 6
) (
    input  logic        clk,
    input  logic        cmdRegsRst,
    input  logic [7:0]  iNodeID,
    input  logic [7:0]  iRxData,
    input  logic [3:0]  iRxByte,
    input  logic        iRxDataReady,
    input  logic        iRxAction,
    input  logic        iRxCrcErr,
    output logic [7:0]  oNodeId,
    output logic [7:0]  oFunc,
    output logic [15:0] oStartAddr,
    output logic [15:0] oRegsQnty,
    output logic        oStopRequest,
    output logic        oBroadcast,
    output logic [2:0]  oErrCode,
    output logic [7:0]  oExcepCode,
    output logic        oReqValid
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic                 rdy_q;
    logic                 act_q;
    logic                 stb;
    logic                 cap_en;
    logic                 node_ok;
    logic                 is_bcast;
    logic [MIN_BYTES-1:0] mask;
    logic [16:0]          span;
    logic [2:0]           err_nx;
    logic [7:0]           excep_nx;
    logic                 bcast_nx;

    assign stb    = iRxDataReady & ~rdy_q;
    assign cap_en = stb & (state == RECV);
    assign span   = {1'b0, oStartAddr} + {1'b0, oRegsQnty};

`ifdef MODBUS_BROADCAST_EN
    assign is_bcast = (oNodeId == 8'h00);
`else
    assign is_bcast = 1'b0;
`endif

    assign node_ok = (oNodeId == iNodeID) | is_bcast;

    // Frame-start detection is edge based so a reset mid-frame
    // waits for the next frame rather than decoding the tail.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (iRxAction & ~act_q) state_nx = RECV;
            RECV:    if (!iRxAction) state_nx = CHECK;
            CHECK:   state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge cmdRegsRst) begin
        if (cmdRegsRst) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        err_nx = 3'd0;
        if (iRxCrcErr || !node_ok || oStopRequest || !(&mask))
            err_nx = 3'd1;
        else if (oFunc != FUNC_CODE)
            err_nx = 3'd2;
        else if (oRegsQnty == 16'd0 || oRegsQnty > 16'(MAX_QNTY))
            err_nx = 3'd3;
        else if (span > 17'h10000)
            err_nx = 3'd4;
    end

    always_comb begin
        excep_nx = 8'h00;
        unique case (1'b1)
            (err_nx == 3'd1): excep_nx = 8'h04;
            (err_nx == 3'd2): excep_nx = 8'h01;
            (err_nx == 3'd3): excep_nx = 8'h03;
            (err_nx == 3'd4): excep_nx = 8'h02;
            default:          excep_nx = 8'h00;
        endcase
    end

    always_comb begin
        bcast_nx = 1'b0;
        if (is_bcast && (&mask))
            bcast_nx = 1'b1;
    end

    always_ff @(posedge clk or posedge cmdRegsRst) begin
        if (cmdRegsRst) begin
            rdy_q        <= 1'b0;
            act_q        <= 1'b1;
            mask         <= '0;
            oNodeId      <= 8'h00;
            oFunc        <= 8'h00;
            oStartAddr   <= 16'h0000;
            oRegsQnty    <= 16'h0000;
            oStopRequest <= 1'b0;
            oBroadcast   <= 1'b0;
            oErrCode     <= 3'd0;
            oExcepCode   <= 8'h00;
            oReqValid    <= 1'b0;
        end else begin
            rdy_q     <= iRxDataReady;
            act_q     <= iRxAction;
            oReqValid <= (state == CHECK);
            if (cap_en) begin
                case (iRxByte)
                    4'd0: begin oNodeId <= iRxData;          mask[0] <= 1'b1; end
                    4'd1: begin oFunc <= iRxData;            mask[1] <= 1'b1; end
                    4'd2: begin oStartAddr[15:8] <= iRxData; mask[2] <= 1'b1; end
                    4'd3: begin oStartAddr[7:0] <= iRxData;  mask[3] <= 1'b1; end
                    4'd4: begin oRegsQnty[15:8] <= iRxData;  mask[4] <= 1'b1; end
                    4'd5: begin oRegsQnty[7:0] <= iRxData;   mask[5] <= 1'b1; end
                    default: ;
                endcase
            end
            if (cap_en && iRxByte == 4'd1 && !node_ok)
                oStopRequest <= 1'b1;
            if (state == CHECK) begin
                oErrCode   <= err_nx;
                oExcepCode <= excep_nx;
                oBroadcast <= bcast_nx;
            end
        end
    end

endmodule

// File: tb/tb_modbus_req_decoder.sv
// Directed bench for modbus_req_decoder: function 03h decoding,
// error classes, latency, mid-frame reset and broadcast handling.
module tb_modbus_req_decoder;

    logic        clk = 1'b0;
    logic        cmdRegsRst = 1'b0;
    logic [7:0]  iNodeID = 8'h01;
    logic [7:0]  iRxData = 8'h00;
    logic [3:0]  iRxByte = 4'd0;
    logic        iRxDataReady = 1'b0;
    logic        iRxAction = 1'b0;
    logic        iRxCrcErr = 1'b0;
    logic [7:0]  oNodeId;
    logic [7:0]  oFunc;
    logic [15:0] oStartAddr;
    logic [15:0] oRegsQnty;
    logic        oStopRequest;
    logic        oBroadcast;
    logic [2:0]  oErrCode;
    logic [7:0]  oExcepCode;
    logic        oReqValid;

    int cmp_n = 0;
    int err_n = 0;

    logic [3:0] fr_ix[8];
    logic [7:0] fr_d[8];
    int         lat;
    logic       stop_pre;
    logic       stop_post;

    always #5 clk = ~clk;

    modbus_req_decoder dut (
        .clk          (clk),
        .cmdRegsRst   (cmdRegsRst),
        .iNodeID      (iNodeID),
        .iRxData      (iRxData),
        .iRxByte      (iRxByte),
        .iRxDataReady (iRxDataReady),
        .iRxAction    (iRxAction),
        .iRxCrcErr    (iRxCrcErr),
        .oNodeId      (oNodeId),
        .oFunc        (oFunc),
        .oStartAddr   (oStartAddr),
        .oRegsQnty    (oRegsQnty),
        .oStopRequest (oStopRequest),
        .oBroadcast   (oBroadcast),
        .oErrCode     (oErrCode),
        .oExcepCode   (oExcepCode),
        .oReqValid    (oReqValid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_std(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4, input logic [7:0] b5);
        for (int i = 0; i < 8; i++) begin
            fr_ix[i] = 4'(i);
            fr_d[i]  = 8'h00;
        end
        fr_d[0] = b0; fr_d[1] = b1; fr_d[2] = b2;
        fr_d[3] = b3; fr_d[4] = b4; fr_d[5] = b5;
    endtask

    task automatic send_byte(input logic [3:0] ix, input logic [7:0] d);
        iRxByte = ix;
        iRxData = d;
        iRxDataReady = 1'b1;
        tick();
        iRxDataReady = 1'b0;
        tick();
    endtask

    task automatic run_frame(input int n, input logic crc, input logic coinc);
        iRxAction = 1'b0;
        iRxDataReady = 1'b0;
        iRxCrcErr = 1'b0;
        cmdRegsRst = 1'b1;
        #1;
        cmdRegsRst = 1'b0;
        tick();
        iRxAction = 1'b1;
        tick();
        tick();
        stop_pre = 1'b0;
        stop_post = 1'b0;
        lat = 0;
        for (int i = 0; i < n; i++) begin
            iRxByte = fr_ix[i];
            iRxData = fr_d[i];
            iRxDataReady = 1'b1;
            if (fr_ix[i] == 4'd1) stop_pre = oStopRequest;
            if (coinc && i == n - 1) begin
                iRxCrcErr = crc;
                iRxAction = 1'b0;
            end
            tick();
            if (fr_ix[i] == 4'd1) stop_post = oStopRequest;
            iRxDataReady = 1'b0;
            if (coinc && i == n - 1) lat = 1;
            else tick();
        end
        if (!coinc) begin
            iRxCrcErr = crc;
            iRxAction = 1'b0;
        end
        while (!oReqValid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        cmdRegsRst = 1'b1;
        #1;
        cmp_n++;
        if ({oNodeId, oFunc, oStartAddr, oRegsQnty} !== 48'h0) begin
            err_n++;
            $display("FAIL reset_fields got %h%h%h%h want 0",
                     oNodeId, oFunc, oStartAddr, oRegsQnty);
        end
        cmp_n++;
        if ({oStopRequest, oBroadcast, oErrCode, oExcepCode, oReqValid} !== 14'h0) begin
            err_n++;
            $display("FAIL reset_status got %b%b %0d %h %b want all 0",
                     oStopRequest, oBroadcast, oErrCode, oExcepCode, oReqValid);
        end
        cmdRegsRst = 1'b0;
        tick();
    endtask

    task automatic test_read_ok();
        set_std(8'h01, 8'h03, 8'h00, 8'h02, 8'h00, 8'h04);
        fr_d[6] = 8'hAA;
        fr_d[7] = 8'hBB;
        run_frame(8, 1'b0, 1'b0);
        cmp_n++;
        if (lat !== 2) begin
            err_n++;
            $display("FAIL ok_latency got %0d want 2", lat);
        end
        cmp_n++;
        if (oErrCode !== 3'd0 || oExcepCode !== 8'h00) begin
            err_n++;
            $display("FAIL ok_err got %0d/%h want 0/00", oErrCode, oExcepCode);
        end
        cmp_n++;
        if (oStartAddr !== 16'h0002 || oRegsQnty !== 16'h0004) begin
            err_n++;
            $display("FAIL ok_fields got %h %h want 0002 0004", oStartAddr, oRegsQnty);
        end
        cmp_n++;
        if (oNodeId !== 8'h01 || oFunc !== 8'h03 || oStopRequest !== 1'b0) begin
            err_n++;
            $display("FAIL ok_hdr got %h %h %b want 01 03 0", oNodeId, oFunc, oStopRequest);
        end
        cmp_n++;
        if (oBroadcast !== 1'b0) begin
            err_n++;
            $display("FAIL ok_bcast got %b want 0", oBroadcast);
        end
        tick();
        cmp_n++;
        if (oReqValid !== 1'b0) begin
            err_n++;
            $display("FAIL ok_pulse got %b want 0", oReqValid);
        end
        iRxAction = 1'b1;
        send_byte(4'd2, 8'h55);
        iRxAction = 1'b0;
        tick();
        cmp_n++;
        if (oStartAddr !== 16'h0002 || oReqValid !== 1'b0) begin
            err_n++;
            $display("FAIL done_hold got %h %b want 0002 0", oStartAddr, oReqValid);
        end
    endtask

    task automatic test_node_mismatch();
        set_std(8'h05, 8'h03, 8'h00, 8'h02, 8'h00, 8'h04);
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (stop_pre !== 1'b0 || stop_post !== 1'b1) begin
            err_n++;
            $display("FAIL stop_timing got %b->%b want 0->1", stop_pre, stop_post);
        end
        cmp_n++;
        if (oErrCode !== 3'd1 || oExcepCode !== 8'h04 || lat !== 2) begin
            err_n++;
            $display("FAIL mismatch_err got %0d/%h lat %0d want 1/04 lat 2",
                     oErrCode, oExcepCode, lat);
        end
    endtask

    task automatic test_bad_func();
        set_std(8'h01, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01);
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd2 || oExcepCode !== 8'h01) begin
            err_n++;
            $display("FAIL bad_func got %0d/%h want 2/01", oErrCode, oExcepCode);
        end
    endtask

    task automatic test_bad_qty();
        set_std(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h7E);
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd3 || oExcepCode !== 8'h03) begin
            err_n++;
            $display("FAIL qty_7e got %0d/%h want 3/03", oErrCode, oExcepCode);
        end
        set_std(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd3) begin
            err_n++;
            $display("FAIL qty_zero got %0d want 3", oErrCode);
        end
        set_std(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h7D);
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd0) begin
            err_n++;
            $display("FAIL qty_7d got %0d want 0", oErrCode);
        end
    endtask

    task automatic test_range();
        set_std(8'h01, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h02);
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd4 || oExcepCode !== 8'h02) begin
            err_n++;
            $display("FAIL range_over got %0d/%h want 4/02", oErrCode, oExcepCode);
        end
        set_std(8'h01, 8'h03, 8'hFF, 8'hFE, 8'h00, 8'h02);
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd0 || oExcepCode !== 8'h00) begin
            err_n++;
            $display("FAIL range_edge got %0d/%h want 0/00", oErrCode, oExcepCode);
        end
    endtask

    task automatic test_crc_short();
        set_std(8'h01, 8'h03, 8'h00, 8'h02, 8'h00, 8'h04);
        run_frame(6, 1'b1, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd1 || oExcepCode !== 8'h04) begin
            err_n++;
            $display("FAIL crc_err got %0d/%h want 1/04", oErrCode, oExcepCode);
        end
        run_frame(4, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd1 || lat !== 2) begin
            err_n++;
            $display("FAIL short_frame got %0d lat %0d want 1 lat 2", oErrCode, lat);
        end
    endtask

    task automatic test_coincident();
        set_std(8'h01, 8'h03, 8'h00, 8'h10, 8'h00, 8'h08);
        run_frame(6, 1'b0, 1'b1);
        cmp_n++;
        if (lat !== 2 || oErrCode !== 3'd0 || oRegsQnty !== 16'h0008) begin
            err_n++;
            $display("FAIL coincident got lat %0d err %0d qty %h want 2 0 0008",
                     lat, oErrCode, oRegsQnty);
        end
    endtask

    task automatic test_duplicate();
        set_std(8'h01, 8'h03, 8'h00, 8'h02, 8'h00, 8'h04);
        fr_ix[6] = 4'd5;
        fr_d[6]  = 8'h05;
        run_frame(7, 1'b0, 1'b0);
        cmp_n++;
        if (oRegsQnty !== 16'h0005 || oErrCode !== 3'd0) begin
            err_n++;
            $display("FAIL duplicate got %h/%0d want 0005/0", oRegsQnty, oErrCode);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        set_std(8'h01, 8'h03, 8'h12, 8'h34, 8'h00, 8'h04);
        run_frame(3, 1'b0, 1'b1);
        cmdRegsRst = 1'b0;
        iRxAction = 1'b0;
        tick();
        cmdRegsRst = 1'b1;
        #1;
        iRxAction = 1'b1;
        tick();
        cmdRegsRst = 1'b0;
        tick();
        iRxAction = 1'b1;
        send_byte(4'd0, 8'h01);
        send_byte(4'd1, 8'h03);
        send_byte(4'd2, 8'h12);
        cmdRegsRst = 1'b1;
        #1;
        cmp_n++;
        if ({oNodeId, oFunc, oStartAddr, oRegsQnty, oErrCode, oReqValid} !== 52'h0) begin
            err_n++;
            $display("FAIL mid_reset_clear got %h %h %h %h %0d %b want 0",
                     oNodeId, oFunc, oStartAddr, oRegsQnty, oErrCode, oReqValid);
        end
        cmdRegsRst = 1'b0;
        tick();
        send_byte(4'd3, 8'h34);
        send_byte(4'd4, 8'h00);
        send_byte(4'd5, 8'h04);
        iRxAction = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (oReqValid) seen++;
        end
        cmp_n++;
        if (seen !== 0 || oStartAddr !== 16'h0000) begin
            err_n++;
            $display("FAIL mid_reset_tail got valid %0d addr %h want 0 0000",
                     seen, oStartAddr);
        end
        run_frame(6, 1'b0, 1'b0);
        cmp_n++;
        if (oErrCode !== 3'd0 || oStartAddr !== 16'h1234 || lat !== 2) begin
            err_n++;
            $display("FAIL after_reset got %0d %h lat %0d want 0 1234 lat 2",
                     oErrCode, oStartAddr, lat);
        end
    endtask

    task automatic test_broadcast();
        set_std(8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01);
        run_frame(6, 1'b0, 1'b0);
`ifdef MODBUS_BROADCAST_EN
        cmp_n++;
        if (oBroadcast !== 1'b1 || oErrCode !== 3'd0 || oStopRequest !== 1'b0) begin
            err_n++;
            $display("FAIL broadcast got b%b e%0d s%b want b1 e0 s0",
                     oBroadcast, oErrCode, oStopRequest);
        end
`else
        cmp_n++;
        if (oBroadcast !== 1'b0 || oErrCode !== 3'd1 || oStopRequest !== 1'b1) begin
            err_n++;
            $display("FAIL node0 got b%b e%0d s%b want b0 e1 s1",
                     oBroadcast, oErrCode, oStopRequest);
        end
`endif
    endtask

    initial begin
        tick();
        test_reset();
        test_read_ok();
        test_node_mismatch();
        test_bad_func();
        test_bad_qty();
        test_range();
        test_crc_short();
        test_coincident();
        test_duplicate();
        test_mid_reset();
        test_broadcast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
